// File: rtl/playback_sequencer_if.sv
// Signal bundle between the playback sequencer, the recording RAM, the tone
// generator and the control logic that issues start/abort.
interface playback_sequencer_if;
    // start, abort and tick are single-cycle strobes with no back-pressure:
    // a strobe is consumed on the one clock edge where it is high, or ignored
    // (start while busy, abort in IDLE); there is no ready signal to wait on.
    logic       start;
    logic       abort;
    logic       tick;
    logic [8:0] rec_len;
    logic [7:0] mem_addr;
    logic [5:0] mem_rdata;
    logic       note_valid;
    logic [2:0] note_code;
    logic [2:0] note_octave;
    logic       busy;
    logic       done;
    logic [2:0] dbg_state;

    modport master (
        output start, abort, tick, rec_len, mem_rdata,
        input  mem_addr, note_valid, note_code, note_octave, busy, done, dbg_state
    );

    modport slave (
        input  start, abort, tick, rec_len, mem_rdata,
        output mem_addr, note_valid, note_code, note_octave, busy, done, dbg_state
    );
endinterface

// File: rtl/playback_sequencer.sv
// Replays recorded 6-bit note entries from the recording RAM, one entry per
// fixed-length note slot, to the tone generator.
module playback_sequencer #(
    parameter int NOTE_TICKS = 64,
    parameter int CNT_W      = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    playback_sequencer_if.slave  bus
);
    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_LOAD   = 3'd2,
        S_PLAY   = 3'd3,
        S_FINISH = 3'd4
    } state_t;

    localparam logic [CNT_W-1:0] LAST_TICK = CNT_W'(NOTE_TICKS - 1);

    state_t           state_q, state_d;
    logic [7:0]       idx_q, idx_d;
    logic [8:0]       len_q, len_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [7:0]       addr_q, addr_d;
    logic             valid_q, valid_d;
    logic [2:0]       code_q, code_d;
    logic [2:0]       oct_q, oct_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    logic start_ok;
    logic slot_end;
    logic last_entry;

    assign start_ok   = bus.start && !bus.abort && !busy_q;
    assign slot_end   = bus.tick && (cnt_q == LAST_TICK);
    // 9-bit compare so a 256-entry recording ends after index 255 instead of wrapping
    assign last_entry = (({1'b0, idx_q} + 9'd1) == len_q);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            idx_q   <= '0;
            len_q   <= '0;
            cnt_q   <= '0;
            addr_q  <= '0;
            valid_q <= 1'b0;
            code_q  <= '0;
            oct_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            len_q   <= len_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            valid_q <= valid_d;
            code_q  <= code_d;
            oct_q   <= oct_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (start_ok) begin
                    state_d = (bus.rec_len == 9'd0) ? S_FINISH : S_FETCH;
                end
            end
            S_FETCH:  state_d = bus.abort ? S_FINISH : S_LOAD;
            S_LOAD:   state_d = bus.abort ? S_FINISH : S_PLAY;
            S_PLAY: begin
                if (bus.abort) begin
                    state_d = S_FINISH;
                end else if (slot_end) begin
                    state_d = last_entry ? S_FINISH : S_FETCH;
                end
            end
            S_FINISH: state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    always_comb begin
        idx_d   = idx_q;
        len_d   = len_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        valid_d = valid_q;
        code_d  = code_q;
        oct_d   = oct_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        case (state_q)
            S_IDLE: begin
                // busy is still high for the one IDLE cycle that follows FINISH
                if (busy_q) begin
                    busy_d = 1'b0;
                end else if (start_ok) begin
                    busy_d = 1'b1;
                    if (bus.rec_len != 9'd0) begin
                        len_d  = bus.rec_len;
                        idx_d  = '0;
                        addr_d = '0;
                    end
                end
            end
            S_FETCH: begin
                if (bus.abort) begin
                    valid_d = 1'b0;
                end
            end
            S_LOAD: begin
                if (bus.abort) begin
                    valid_d = 1'b0;
                end else begin
                    code_d  = bus.mem_rdata[2:0];
                    oct_d   = bus.mem_rdata[5:3];
                    valid_d = (bus.mem_rdata[2:0] != 3'd0);
                    cnt_d   = '0;
                end
            end
            S_PLAY: begin
                if (bus.abort) begin
                    valid_d = 1'b0;
                end else if (bus.tick) begin
                    cnt_d = cnt_q + 1'b1;
                    if (slot_end) begin
                        if (last_entry) begin
                            valid_d = 1'b0;
                        end else begin
                            idx_d  = idx_q + 8'd1;
                            addr_d = idx_q + 8'd1;
                        end
                    end
                end
            end
            S_FINISH: done_d = 1'b1;
            default: ;
        endcase
    end

    assign bus.mem_addr    = addr_q;
    assign bus.note_valid  = valid_q;
    assign bus.note_code   = code_q;
    assign bus.note_octave = oct_q;
    assign bus.busy        = busy_q;
    assign bus.done        = done_q;
    assign bus.dbg_state   = state_q;
endmodule

// File: tb/tb_playback_sequencer.sv
// Directed bench for playback_sequencer: a RAM model, a free-running tick,
// a note scoreboard fed at start time and drained as each slot begins.
module tb_playback_sequencer;
    localparam int NOTE_TICKS = 4;
    localparam int CNT_W      = 8;
    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_FETCH  = 3'd1;
    localparam logic [2:0] ST_LOAD   = 3'd2;
    localparam logic [2:0] ST_PLAY   = 3'd3;
    localparam logic [2:0] ST_FINISH = 3'd4;

    logic clk = 1'b0;
    logic rst_n;

    playback_sequencer_if bus ();

    playback_sequencer #(.NOTE_TICKS(NOTE_TICKS), .CNT_W(CNT_W)) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    logic [5:0] mem [256];
    always @(posedge clk) bus.mem_rdata <= mem[bus.mem_addr];

    int tick_ph = 0;
    initial begin
        bus.tick = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            bus.tick = (tick_ph == 2);
            tick_ph  = (tick_ph == 2) ? 0 : tick_ph + 1;
        end
    end

    logic [14:0] exp_q[$];
    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic push_exp(input logic [7:0] addr, input logic [5:0] entry);
        exp_q.push_back({addr, (entry[2:0] != 3'd0), entry[5:3], entry[2:0]});
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic start_play(input logic [8:0] len);
        bus.rec_len = len;
        bus.start   = 1'b1;
        step();
        bus.start   = 1'b0;
    endtask

    task automatic wait_state_addr(input logic [2:0] st, input logic [7:0] addr,
                                   input int budget, input string tag);
        logic found = 1'b0;
        for (int i = 0; i < budget; i++) begin
            if (bus.dbg_state == st && bus.mem_addr == addr) begin
                found = 1'b1;
                break;
            end
            step();
        end
        chk(tag, found, 1);
    endtask

    task automatic wait_done(input int budget, input string tag);
        logic found = 1'b0;
        for (int i = 0; i < budget; i++) begin
            step();
            if (bus.done) begin
                found = 1'b1;
                break;
            end
        end
        chk(tag, found, 1);
        if (found) begin
            chk({tag, "_busy_in_done"}, bus.busy, 1);
            chk({tag, "_nv_in_done"}, bus.note_valid, 0);
            step();
            chk({tag, "_done_1cyc"}, bus.done, 0);
            chk({tag, "_busy_low"}, bus.busy, 0);
        end
    endtask

    logic [2:0] prev_state = ST_IDLE;
    logic       prev_tick  = 1'b0;
    logic       prev_abort = 1'b0;
    int         tcnt       = 0;

    // Each LOAD->PLAY transition is one slot starting: pop and compare its note.
    initial begin
        logic [14:0] obs;
        logic [14:0] exp;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                prev_state = ST_IDLE;
                prev_tick  = 1'b0;
                prev_abort = 1'b0;
                tcnt       = 0;
            end else begin
                if (prev_state == ST_PLAY && prev_tick) tcnt++;
                if (prev_state == ST_LOAD && bus.dbg_state == ST_PLAY) begin
                    obs = {bus.mem_addr, bus.note_valid, bus.note_octave, bus.note_code};
                    if (exp_q.size() > 0) begin
                        exp = exp_q.pop_front();
                        chk("slot_note", obs, exp);
                    end else begin
                        chk("slot_unexpected", exp_q.size(), 1);
                    end
                    tcnt = 0;
                end
                if (prev_state == ST_PLAY && bus.dbg_state != ST_PLAY && !prev_abort)
                    chk("slot_ticks", tcnt, NOTE_TICKS);
                prev_state = bus.dbg_state;
                prev_tick  = bus.tick;
                prev_abort = bus.abort;
            end
        end
    end

    initial begin
        bus.start   = 1'b0;
        bus.abort   = 1'b0;
        bus.rec_len = '0;
        for (int i = 0; i < 256; i++) mem[i] = 6'd0;
        rst_n = 1'b0;
        step();
        step();
        chk("rst_addr", bus.mem_addr, 0);
        chk("rst_nv", bus.note_valid, 0);
        chk("rst_code", bus.note_code, 0);
        chk("rst_oct", bus.note_octave, 0);
        chk("rst_busy", bus.busy, 0);
        chk("rst_done", bus.done, 0);
        chk("rst_state", bus.dbg_state, ST_IDLE);
        rst_n = 1'b1;
        step();

        // Empty recording
        start_play(9'd0);
        chk("empty_busy", bus.busy, 1);
        chk("empty_done_early", bus.done, 0);
        step();
        chk("empty_done", bus.done, 1);
        chk("empty_nv", bus.note_valid, 0);
        chk("empty_addr", bus.mem_addr, 0);
        step();
        chk("empty_done_clr", bus.done, 0);
        chk("empty_busy_clr", bus.busy, 0);

        // Basic replay
        mem[0] = {3'd4, 3'd1};
        mem[1] = {3'd4, 3'd3};
        mem[2] = {3'd5, 3'd5};
        for (int i = 0; i < 3; i++) push_exp(8'(i), mem[i]);
        start_play(9'd3);
        chk("basic_busy", bus.busy, 1);
        chk("basic_addr0", bus.mem_addr, 0);
        chk("basic_fetch", bus.dbg_state, ST_FETCH);
        step();
        chk("basic_load", bus.dbg_state, ST_LOAD);
        step();
        chk("basic_first_nv", bus.note_valid, 1);
        chk("basic_first_code", bus.note_code, 1);
        chk("basic_first_oct", bus.note_octave, 4);
        wait_done(300, "basic_done");
        chk("basic_keep_code", bus.note_code, 5);
        chk("basic_keep_oct", bus.note_octave, 5);
        chk("basic_queue", exp_q.size(), 0);

        // Rest slot; rec_len changes mid-play must not matter
        mem[0] = {3'd3, 3'd2};
        mem[1] = 6'd0;
        mem[2] = {3'd3, 3'd7};
        for (int i = 0; i < 3; i++) push_exp(8'(i), mem[i]);
        start_play(9'd3);
        bus.rec_len = 9'd1;
        wait_done(300, "rest_done");
        chk("rest_addr_end", bus.mem_addr, 2);
        chk("rest_queue", exp_q.size(), 0);

        // Full buffer
        for (int i = 0; i < 256; i++) begin
            mem[i] = 6'($urandom_range(0, 63));
            push_exp(8'(i), mem[i]);
        end
        start_play(9'd256);
        wait_done(6000, "full_done");
        chk("full_addr_end", bus.mem_addr, 255);
        chk("full_queue", exp_q.size(), 0);

        // Abort on the 2nd note, with a start while busy first
        mem[0] = {3'd2, 3'd1};
        mem[1] = {3'd2, 3'd2};
        mem[2] = {3'd2, 3'd3};
        push_exp(8'd0, mem[0]);
        push_exp(8'd1, mem[1]);
        start_play(9'd3);
        wait_state_addr(ST_PLAY, 8'd0, 20, "abort_reach_play0");
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        chk("busy_start_state", bus.dbg_state, ST_PLAY);
        chk("busy_start_addr", bus.mem_addr, 0);
        chk("busy_start_busy", bus.busy, 1);
        wait_state_addr(ST_PLAY, 8'd1, 100, "abort_reach_play1");
        step();
        bus.abort = 1'b1;
        step();
        bus.abort = 1'b0;
        chk("abort_nv", bus.note_valid, 0);
        chk("abort_state", bus.dbg_state, ST_FINISH);
        chk("abort_done_early", bus.done, 0);
        step();
        chk("abort_done", bus.done, 1);
        step();
        chk("abort_done_clr", bus.done, 0);
        chk("abort_busy_clr", bus.busy, 0);
        chk("abort_queue", exp_q.size(), 0);

        // start + abort together in IDLE
        bus.rec_len = 9'd3;
        bus.start   = 1'b1;
        bus.abort   = 1'b1;
        step();
        bus.start   = 1'b0;
        bus.abort   = 1'b0;
        chk("collide_state", bus.dbg_state, ST_IDLE);
        chk("collide_busy", bus.busy, 0);
        step();
        chk("collide_done", bus.done, 0);
        chk("collide_state2", bus.dbg_state, ST_IDLE);

        // Asynchronous reset mid-play, then replay from entry 0
        for (int i = 0; i < 3; i++) push_exp(8'(i), mem[i]);
        start_play(9'd3);
        wait_state_addr(ST_PLAY, 8'd1, 100, "areset_reach_play1");
        step();
        #2;
        rst_n = 1'b0;
        #1;
        chk("areset_addr", bus.mem_addr, 0);
        chk("areset_nv", bus.note_valid, 0);
        chk("areset_code", bus.note_code, 0);
        chk("areset_oct", bus.note_octave, 0);
        chk("areset_busy", bus.busy, 0);
        chk("areset_done", bus.done, 0);
        exp_q.delete();
        step();
        step();
        rst_n = 1'b1;
        step();
        for (int i = 0; i < 3; i++) push_exp(8'(i), mem[i]);
        start_play(9'd3);
        wait_done(300, "replay_done");
        chk("replay_queue", exp_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
